lsu_mem_stage: RTL and testbench

//  Load/store unit directly downstream of the execute-stage ALU. It takes the
//  ALU result as the effective address and drives a single-port data memory

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_load_align.sv | 21 ++
 rtl/lsu_mem_stage.sv | 121 ++++++++++++
 tb/tb_lsu_mem_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return BE_BYTE0 << lane;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load result alignment: selects the addressed byte lane and zero-extends it.
module lsu_load_align #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            lane,
  input  logic                  is_byte,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0] byte_val;

  always_comb begin
    byte_val = rdata[8*lane +: 8];
    data     = rdata;
    if (is_byte) begin
      data = {{(DATA_WIDTH-8){1'b0}}, byte_val};
    end
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage of the LSU: accepts LW/SW/LBU/SB from execute, runs a req/ack
// access with timeout, and returns load data to writeback.
module lsu_mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_load,
  input  logic                  ex_store,
  input  logic                  ex_byte,
  input  logic [DATA_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  output logic                  stall,
  output logic                  wb_valid,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  import lsu_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic            load_q;
  logic            byte_q;
  logic [1:0]      lane_q;
  logic            op_sel;
  logic            misalign;
  logic            accept;
  logic            bad_op;
  logic [DATA_WIDTH-1:0] align_data;

  always_comb begin
    op_sel   = ex_valid & (ex_load ^ ex_store);
    misalign = ~ex_byte & (ex_addr[1:0] != 2'b00);
    accept   = (state == IDLE) & op_sel & ~misalign;
    bad_op   = (state == IDLE) & ex_valid &
               ((ex_load & ex_store) | (op_sel & misalign));
    stall    = (state == BUSY) | accept;
  end

  lsu_load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .rdata  (mem_rdata),
    .lane   (lane_q),
    .is_byte(byte_q),
    .data   (align_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      load_q    <= 1'b0;
      byte_q    <= 1'b0;
      lane_q    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      err      <= 1'b0;
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= BUSY;
            cnt       <= '0;
            load_q    <= ex_load;
            byte_q    <= ex_byte;
            lane_q    <= ex_addr[1:0];
            mem_req   <= 1'b1;
            mem_we    <= ex_store;
            mem_addr  <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be    <= ex_byte ? lane_mask(ex_addr[1:0]) : BE_WORD;
            mem_wdata <= ex_byte ? {4{ex_wdata[7:0]}} : ex_wdata;
          end else if (bad_op) begin
            err <= 1'b1;
          end
        end
        BUSY: begin
          // Ack is checked before the timeout so a last-cycle ack still completes.
          if (mem_ack) begin
            mem_req  <= 1'b0;
            state    <= RESP;
            wb_valid <= load_q;
            if (load_q) begin
              wb_data <= align_data;
            end
          end else if (cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_load = 1'b0;
  logic        ex_store = 1'b0;
  logic        ex_byte = 1'b0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT   (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_valid (ex_valid),
    .ex_load  (ex_load),
    .ex_store (ex_store),
    .ex_byte  (ex_byte),
    .ex_addr  (ex_addr),
    .ex_wdata (ex_wdata),
    .stall    (stall),
    .wb_valid (wb_valid),
    .wb_data  (wb_data),
    .err      (err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic ld, input logic st, input logic by,
                    input logic [31:0] a, input logic [31:0] d);
    ex_valid = 1'b1;
    ex_load  = ld;
    ex_store = st;
    ex_byte  = by;
    ex_addr  = a;
    ex_wdata = d;
  endtask

  task automatic no_op();
    ex_valid = 1'b0;
    ex_load  = 1'b0;
    ex_store = 1'b0;
    ex_byte  = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);

    // 1: reset during an outstanding store
    op(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
    #1;
    chk("t1_stall_t0", {31'd0, stall}, 32'd1);
    tick();
    no_op();
    chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t1_req_dropped", {31'd0, mem_req}, 32'd0);
    chk("t1_no_err", {31'd0, err}, 32'd0);
    chk("t1_no_wb", {31'd0, wb_valid}, 32'd0);
    #1;
    chk("t1_stall_idle", {31'd0, stall}, 32'd0);

    // 2: word store, ack at T1
    op(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
    #1;
    chk("t2_stall_t0", {31'd0, stall}, 32'd1);
    tick();
    no_op();
    mem_ack = 1'b1;
    chk("t2_mem_req", {31'd0, mem_req}, 32'd1);
    chk("t2_mem_we", {31'd0, mem_we}, 32'd1);
    chk("t2_mem_addr", mem_addr, 32'h100);
    chk("t2_mem_be", {28'd0, mem_be}, 32'hF);
    chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
    #1;
    chk("t2_stall_t1", {31'd0, stall}, 32'd1);
    tick();
    mem_ack = 1'b0;
    chk("t2_req_drop", {31'd0, mem_req}, 32'd0);
    chk("t2_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("t2_stall_resp", {31'd0, stall}, 32'd0);
    tick();
    chk("t2_no_wb_after", {31'd0, wb_valid}, 32'd0);

    // 3: byte store to lane 3
    op(1'b0, 1'b1, 1'b1, 32'h103, 32'h000000A5);
    tick();
    no_op();
    mem_ack = 1'b1;
    chk("t3_mem_addr", mem_addr, 32'h100);
    chk("t3_mem_be", {28'd0, mem_be}, 32'h8);
    chk("t3_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    tick();
    mem_ack = 1'b0;
    tick();

    // 4: byte load from lane 2, ack three cycles late
    op(1'b1, 1'b0, 1'b1, 32'h102, 32'h0);
    tick();
    no_op();
    chk("t4_mem_we", {31'd0, mem_we}, 32'd0);
    chk("t4_mem_be", {28'd0, mem_be}, 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_req_held", {31'd0, mem_req}, 32'd1);
      chk("t4_wb_quiet", {31'd0, wb_valid}, 32'd0);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h11223344;
    tick();
    mem_ack = 1'b0;
    chk("t4_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t4_wb_data", wb_data, 32'h00000022);
    chk("t4_req_drop", {31'd0, mem_req}, 32'd0);
    tick();
    chk("t4_wb_pulse", {31'd0, wb_valid}, 32'd0);

    // ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
    chk("idle_ack_wb", {31'd0, wb_valid}, 32'd0);

    // 5: misaligned word load
    op(1'b1, 1'b0, 1'b0, 32'h6, 32'h0);
    #1;
    chk("t5_stall", {31'd0, stall}, 32'd0);
    tick();
    no_op();
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_no_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("t5_err_pulse", {31'd0, err}, 32'd0);
    chk("t5_no_req2", {31'd0, mem_req}, 32'd0);

    // load and store both set -> err; neither set -> ignored
    op(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    chk("both_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("both_err", {31'd0, err}, 32'd1);
    chk("both_no_req", {31'd0, mem_req}, 32'd0);
    op(1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
    #1;
    chk("alu_stall", {31'd0, stall}, 32'd0);
    tick();
    no_op();
    chk("alu_no_err", {31'd0, err}, 32'd0);
    chk("alu_no_req", {31'd0, mem_req}, 32'd0);

    // 6a: timeout with no ack
    op(1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
    tick();
    no_op();
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("t6_req_held", {31'd0, mem_req}, 32'd1);
      chk("t6_no_err_yet", {31'd0, err}, 32'd0);
    end
    tick();
    chk("t6_err", {31'd0, err}, 32'd1);
    chk("t6_req_drop", {31'd0, mem_req}, 32'd0);
    chk("t6_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("t6_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("t6_err_pulse", {31'd0, err}, 32'd0);

    // 6b: ack on the 16th busy cycle wins over timeout
    op(1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
    tick();
    no_op();
    for (int i = 1; i < 16; i++) begin
      tick();
    end
    chk("t6b_req_held", {31'd0, mem_req}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0;
    chk("t6b_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("t6b_no_err", {31'd0, err}, 32'd0);
    chk("t6b_wb_data", wb_data, 32'hCAFEF00D);
    tick();
    chk("t6b_no_err2", {31'd0, err}, 32'd0);
    chk("t6b_wb_pulse", {31'd0, wb_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
